// File: rtl/mac_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and helpers for the mac_accum dot-product
//               accumulator: default multiplier latency, FSM state encoding
//               and the accumulator width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Latency of the upstream shift-add multiplier (multi_pipe)
  localparam int MUL_LAT_DEF = 2;

  // Accumulator FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width that holds max_len full-scale size x size products without overflow
  function automatic int acc_width(input int size, input int max_len);
    return 2 * size + $clog2(max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_accum_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : valid_delay
// Description : DEPTH-deep shift register of {v, last} beat tags. Stage 0
//               loads the input tag; the tail stage is presented as
//               d_v/d_last. Per-stage (v & last) flags are exported so the
//               owner can see whether a vector end is still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  input  logic             in_last,
  output logic             d_v,
  output logic             d_last,
  output logic [DEPTH-1:0] stage_last
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] last_q, last_d;

  // Shift every tag one stage toward the tail, new tag into stage 0
  always_comb begin
    v_d       = v_q;
    last_d    = last_q;
    v_d[0]    = in_v;
    last_d[0] = in_last;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = v_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // Tag registers, cleared on reset so in-flight beats are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      last_q <= '0;
    end else begin
      v_q    <= v_d;
      last_q <= last_d;
    end
  end

  assign d_v        = v_q[DEPTH-1];
  assign d_last     = last_q[DEPTH-1];
  assign stage_last = v_q & last_q;

endmodule
`default_nettype wire

// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : mac_accum
// Description : Dot-product accumulator behind the pipelined multiplier.
//               Tracks accepted beats through a latency-matched delay line,
//               sums one vector of products and presents the result on a
//               valid/ready port. in_ready throttles the operand source since
//               the multiplier cannot stall.
//               Build option MAC_ACCUM_SAT_EN: accumulator saturates at
//               all-ones and flags out_err instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accum
  import mac_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1),
  parameter int ACC_W   = acc_width(SIZE, MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_err
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_err_q, out_err_d;

  logic               d_v;
  logic               d_last;
  logic [MUL_LAT-1:0] stage_last;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_res;
  logic               add_ovf;
  logic               len_full;

  valid_delay #(
    .DEPTH (MUL_LAT)
  ) u_valid_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_v       (in_valid & in_ready),
    .in_last    (in_last),
    .d_v        (d_v),
    .d_last     (d_last),
    .stage_last (stage_last)
  );

  // Stop accepting once a vector end is in flight and until the result has
  // been handed off. DONE is included so the source stays blocked in the
  // cycle between the last product landing and out_valid rising.
  assign in_ready = !(|stage_last) && !out_valid_q && (state_q != DONE);

  assign prod_ext = ACC_W'(prod);
  assign len_full = (cnt_q == CNT_W'(MAX_LEN));

`ifdef MAC_ACCUM_SAT_EN
  logic [ACC_W:0] sum_full;

  // Saturating add: clamp to all-ones on carry-out and report it
  always_comb begin
    sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
    add_ovf  = sum_full[ACC_W];
    add_res  = add_ovf ? '1 : sum_full[ACC_W-1:0];
  end
`else
  // Modulo add: wrap is only reachable after a length error
  always_comb begin
    add_res = acc_q + prod_ext;
    add_ovf = 1'b0;
  end
`endif

  // Next-state and datapath: accumulate products, then hold the result
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (d_v) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = d_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (d_v) begin
          acc_d = add_res;
          // Counter saturates; extra beats flag the vector but still add
          if (len_full) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (add_ovf) begin
            err_d = 1'b1;
          end
          if (d_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_sum_d   = acc_q;
          out_cnt_d   = cnt_q;
          out_err_d   = err_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mac_accum
// Description : Self-checking bench for mac_accum. A behavioural multiplier
//               stand-in feeds prod; expected results come from summing the
//               operand products of each vector with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accum;

  localparam int SIZE    = 4;
  localparam int MUL_LAT = 2;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int ACC_W   = 2 * SIZE + $clog2(MAX_LEN);

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              in_last   = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_err;
  logic [2*SIZE-1:0] prod;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_cnt;
  logic [SIZE-1:0]   op_a = '0;
  logic [SIZE-1:0]   op_b = '0;
  logic [2*SIZE-1:0] mp [MUL_LAT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Current vector: operands and idle cycles before each beat
  int ba   [64];
  int bb   [64];
  int bgap [64];
  int nb;

  mac_accum #(
    .SIZE    (SIZE),
    .MUL_LAT (MUL_LAT),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Non-stalling multiplier stand-in with MUL_LAT register stages
  always @(posedge clk) begin
    mp[0] <= op_a * op_b;
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign prod = mp[MUL_LAT-1];

  // Expected result of the current vector
  task automatic model(output longint s, output int c, output bit e);
    longint full = 0;
    longint top  = (longint'(1) << ACC_W) - 1;
    for (int i = 0; i < nb; i++) full += longint'(ba[i] * bb[i]);
    c = (nb > MAX_LEN) ? MAX_LEN : nb;
    e = (nb > MAX_LEN);
`ifdef MAC_ACCUM_SAT_EN
    if (full > top) begin
      s = top;
      e = 1'b1;
    end else begin
      s = full;
    end
`else
    s = full & top;
`endif
  endtask

  // Present each beat from a negedge and hold until accepted
  task automatic drive_vector(output bit ok, output int acc_cyc);
    int n;
    ok = 1'b1;
    acc_cyc = 0;
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (bgap[i]) @(negedge clk);
      op_a     = SIZE'(ba[i]);
      op_b     = SIZE'(bb[i]);
      in_last  = (i == nb - 1);
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (in_ready !== 1'b1) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bounded wait for out_valid; reports the edge index it was seen after
  task automatic wait_result(output bit ok, output int vcyc);
    int n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok   = (out_valid === 1'b1);
    vcyc = cyc;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_sum, out_cnt, out_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b sum=%0d cnt=%0d err=%0b, want all 0",
               out_valid, out_sum, out_cnt, out_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok1, ok2, ee;
    int lc, vc, ec;
    longint es;
    nb = 3;
    ba[0] = 3;  bb[0] = 5;  bgap[0] = 0;
    ba[1] = 2;  bb[1] = 7;  bgap[1] = 0;
    ba[2] = 15; bb[2] = 15; bgap[2] = 0;
    out_ready = 1'b1;
    drive_vector(ok1, lc);
    wait_result(ok2, vc);
    model(es, ec, ee);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL basic_timeout: accept_ok=%0b result_ok=%0b want 1 1", ok1, ok2);
    end
    checks++;
    if (vc - lc != MUL_LAT + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges want %0d", vc - lc, MUL_LAT + 1);
    end
    checks++;
    if (out_sum !== es[ACC_W-1:0]) begin
      errors++;
      $display("FAIL basic_sum: got %0d want %0d", out_sum, es);
    end
    checks++;
    if (out_cnt !== CNT_W'(ec) || out_err !== ee) begin
      errors++;
      $display("FAIL basic_cnt_err: got cnt=%0d err=%0b want cnt=%0d err=%0b",
               out_cnt, out_err, ec, ee);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_width: out_valid=%0b one cycle later, want 0", out_valid);
    end
  endtask

  task automatic test_single();
    bit ok1, ee, low_bad;
    int lc, ec, n;
    longint es;
    nb = 1;
    ba[0] = 15; bb[0] = 15; bgap[0] = 0;
    out_ready = 1'b1;
    drive_vector(ok1, lc);
    model(es, ec, ee);
    low_bad = 1'b0;
    n = 0;
    while (n < 50) begin
      if (in_ready !== 1'b0) low_bad = 1'b1;
      if (out_valid === 1'b1) break;
      @(negedge clk);
      n++;
    end
    checks++;
    if (low_bad || !ok1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready_low: in_ready_seen_high=%0b valid=%0b want 0 1",
               low_bad, out_valid);
    end
    checks++;
    if (out_sum !== es[ACC_W-1:0] || out_cnt !== CNT_W'(ec)) begin
      errors++;
      $display("FAIL single_result: got sum=%0d cnt=%0d want sum=%0d cnt=%0d",
               out_sum, out_cnt, es, ec);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got in_ready=%0b valid=%0b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, ee, bad;
    int lc, vc, ec, t0;
    longint es;
    nb = 2;
    for (int i = 0; i < nb; i++) begin
      ba[i]   = $urandom_range(0, 15);
      bb[i]   = $urandom_range(0, 15);
      bgap[i] = 0;
    end
    out_ready = 1'b0;
    drive_vector(ok1, lc);
    wait_result(ok2, vc);
    model(es, ec, ee);
    bad = !(ok1 && ok2);
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== es[ACC_W-1:0] ||
          out_cnt !== CNT_W'(ec) || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got valid=%0b sum=%0d cnt=%0d in_ready=%0b want 1 %0d %0d 0",
               out_valid, out_sum, out_cnt, in_ready, es, ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%0b valid=%0b want 1 0", in_ready, out_valid);
    end
    nb = 1;
    ba[0] = 6; bb[0] = 9; bgap[0] = 0;
    t0 = cyc;
    drive_vector(ok1, lc);
    checks++;
    if (!ok1 || lc != t0 + 1) begin
      errors++;
      $display("FAIL bp_next_accept: accepted at edge %0d want %0d", lc, t0 + 1);
    end
    wait_result(ok2, vc);
    model(es, ec, ee);
    checks++;
    if (!ok2 || out_sum !== es[ACC_W-1:0]) begin
      errors++;
      $display("FAIL bp_next_sum: got %0d want %0d", out_sum, es);
    end
    @(negedge clk);
  endtask

  task automatic test_gapped();
    bit ok1, ok2, ee;
    int lc, vc, ec;
    longint es;
    nb = 2;
    ba[0] = 1; bb[0] = 1; bgap[0] = 0;
    ba[1] = 2; bb[1] = 2; bgap[1] = 3;
    out_ready = 1'b1;
    drive_vector(ok1, lc);
    wait_result(ok2, vc);
    model(es, ec, ee);
    checks++;
    if (!(ok1 && ok2) || out_sum !== es[ACC_W-1:0]) begin
      errors++;
      $display("FAIL gap_sum: got %0d want %0d", out_sum, es);
    end
    checks++;
    if (out_cnt !== CNT_W'(ec) || out_err !== ee) begin
      errors++;
      $display("FAIL gap_cnt: got cnt=%0d err=%0b want cnt=%0d err=%0b",
               out_cnt, out_err, ec, ee);
    end
    @(negedge clk);
  endtask

  task automatic test_length_err();
    bit ok1, ok2, ee;
    int lc, vc, ec;
    longint es;
    nb = MAX_LEN + 1;
    for (int i = 0; i < nb; i++) begin
      ba[i] = 15; bb[i] = 15; bgap[i] = 0;
    end
    out_ready = 1'b1;
    drive_vector(ok1, lc);
    wait_result(ok2, vc);
    model(es, ec, ee);
    checks++;
    if (!(ok1 && ok2) || out_cnt !== CNT_W'(ec) || out_err !== ee) begin
      errors++;
      $display("FAIL len_cnt_err: got cnt=%0d err=%0b want cnt=%0d err=%0b",
               out_cnt, out_err, ec, ee);
    end
    checks++;
    if (out_sum !== es[ACC_W-1:0]) begin
      errors++;
      $display("FAIL len_sum: got %0d want %0d", out_sum, es);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, ee, bad;
    int lc, vc, ec;
    longint es;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_a = 4'd7; op_b = 4'd9; in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sum, out_cnt, out_err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%0b sum=%0d cnt=%0d err=%0b want all 0",
               out_valid, out_sum, out_cnt, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    nb = 1;
    ba[0] = 4; bb[0] = 4; bgap[0] = 0;
    drive_vector(ok1, lc);
    wait_result(ok2, vc);
    model(es, ec, ee);
    checks++;
    if (!(ok1 && ok2) || out_sum !== es[ACC_W-1:0] || out_cnt !== CNT_W'(ec)) begin
      errors++;
      $display("FAIL midrst_next: got sum=%0d cnt=%0d want sum=%0d cnt=%0d",
               out_sum, out_cnt, es, ec);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok1, ok2, ee, bad;
    int lc, vc, ec, hold;
    longint es;
    for (int v = 0; v < 20; v++) begin
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) begin
        ba[i]   = $urandom_range(0, 15);
        bb[i]   = $urandom_range(0, 15);
        bgap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      out_ready = 1'b0;
      drive_vector(ok1, lc);
      wait_result(ok2, vc);
      model(es, ec, ee);
      checks++;
      if (!(ok1 && ok2)) begin
        errors++;
        $display("FAIL rand_timeout v%0d: accept_ok=%0b result_ok=%0b want 1 1", v, ok1, ok2);
      end
      checks++;
      if (vc - lc != MUL_LAT + 1) begin
        errors++;
        $display("FAIL rand_latency v%0d: got %0d edges want %0d", v, vc - lc, MUL_LAT + 1);
      end
      checks++;
      if (out_sum !== es[ACC_W-1:0]) begin
        errors++;
        $display("FAIL rand_sum v%0d: got %0d want %0d", v, out_sum, es);
      end
      checks++;
      if (out_cnt !== CNT_W'(ec) || out_err !== ee) begin
        errors++;
        $display("FAIL rand_cnt_err v%0d: got cnt=%0d err=%0b want cnt=%0d err=%0b",
                 v, out_cnt, out_err, ec, ee);
      end
      hold = $urandom_range(0, 3);
      bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_sum !== es[ACC_W-1:0] || in_ready !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand_hold v%0d: got valid=%0b sum=%0d in_ready=%0b want 1 %0d 0",
                 v, out_valid, out_sum, in_ready, es);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_release v%0d: got valid=%0b in_ready=%0b want 0 1",
                 v, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_gapped();
    test_length_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
